// File: rtl/power_accum_ctrl.sv
// Sequencer for the shift-add multiplier: launches one multiply per voltage/current
// sample pair, accumulates the products with saturation and publishes windowed energy.
module power_accum_ctrl #(
    parameter int P_W     = 64,
    parameter int ACC_W   = 80,
    parameter int WINDOW  = 1000,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             smp_valid,
    output logic             smp_ready,
    input  logic [31:0]      smp_v,
    input  logic [31:0]      smp_i,
    output logic [31:0]      mult_a,
    output logic [31:0]      mult_b,
    output logic             mult_init,
    input  logic             mult_done,
    input  logic [P_W-1:0]   mult_pp,
    output logic [ACC_W-1:0] energy,
    output logic             energy_valid,
    output logic             overflow,
    output logic             timeout_err,
    output logic             busy
);

    // Counters only ever hold 0..N-1; the terminal value is detected one step early.
    localparam int CNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int SUM_W = ACC_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_ACCUM,
        S_REL
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               done_q;
    logic [TMO_W-1:0]   wait_cnt;
    logic [P_W-1:0]     product;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   smp_cnt;

    logic               xfer;
    logic               done_rise;
    logic               tmo_hit;
    logic               win_end;
    logic [SUM_W-1:0]   sum;
    logic [ACC_W-1:0]   acc_res;

    assign smp_ready = (state == S_IDLE) && !mult_done;
    assign xfer      = smp_valid && smp_ready;
    assign done_rise = mult_done && !done_q;
    assign tmo_hit   = (wait_cnt == TMO_W'(TIMEOUT - 1));
    assign win_end   = (smp_cnt == CNT_W'(WINDOW - 1));
    assign mult_init = (state == S_LAUNCH);
    assign busy      = (state != S_IDLE);

    // The extra top bit is the carry that signals saturation.
    assign sum     = {1'b0, acc} + SUM_W'(product);
    assign acc_res = sum[ACC_W] ? '1 : sum[ACC_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        // NOTE: default assigned first so every path drives state_nxt; no latch is inferred.
        state_nxt = state;
        case (state)
            S_IDLE:   if (xfer) state_nxt = S_LAUNCH;
            S_LAUNCH: state_nxt = S_WAIT;
            S_WAIT: begin
                if (done_rise)    state_nxt = S_ACCUM;
                else if (tmo_hit) state_nxt = S_REL;
            end
            S_ACCUM:  state_nxt = S_REL;
            S_REL:    if (!mult_done) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mult_a       <= '0;
            mult_b       <= '0;
            done_q       <= 1'b0;
            wait_cnt     <= '0;
            product      <= '0;
            acc          <= '0;
            smp_cnt      <= '0;
            energy       <= '0;
            energy_valid <= 1'b0;
            overflow     <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout, so every read here sees the pre-edge value.
            done_q       <= mult_done;
            energy_valid <= 1'b0;
            // Overflow stays visible alongside the energy pulse, then clears for the new window.
            if (energy_valid) overflow <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (xfer) begin
                        mult_a <= smp_v;
                        mult_b <= smp_i;
                    end
                end
                S_LAUNCH: wait_cnt <= '0;
                S_WAIT: begin
                    wait_cnt <= wait_cnt + TMO_W'(1);
                    if (done_rise)    product     <= mult_pp;
                    else if (tmo_hit) timeout_err <= 1'b1;
                end
                S_ACCUM: begin
                    if (sum[ACC_W]) overflow <= 1'b1;
                    if (win_end) begin
                        energy       <= acc_res;
                        energy_valid <= 1'b1;
                        acc          <= '0;
                        smp_cnt      <= '0;
                    end else begin
                        acc     <= acc_res;
                        smp_cnt <= smp_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_power_accum_ctrl.sv
// Bench for power_accum_ctrl: two instances (window 4 / 64-bit acc, window 1 / 80-bit acc)
// driven by a scripted multiplier and checked every cycle against a transaction-level model.
module tb_power_accum_ctrl;

    localparam int TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        smp_valid = 1'b0;
    logic [31:0] smp_v = '0;
    logic [31:0] smp_i = '0;
    logic        mult_done = 1'b0;
    logic [63:0] mult_pp = '0;

    always #5 clk = ~clk;

    logic        w4_ready, w4_init, w4_ev, w4_ovf, w4_terr, w4_busy;
    logic [31:0] w4_a, w4_b;
    logic [63:0] w4_energy;
    logic        w1_ready, w1_init, w1_ev, w1_ovf, w1_terr, w1_busy;
    logic [31:0] w1_a, w1_b;
    logic [79:0] w1_energy;

    power_accum_ctrl #(.P_W(64), .ACC_W(64), .WINDOW(4), .TIMEOUT(TIMEOUT)) u_w4 (
        .clk(clk), .rst(rst), .smp_valid(smp_valid), .smp_ready(w4_ready),
        .smp_v(smp_v), .smp_i(smp_i), .mult_a(w4_a), .mult_b(w4_b), .mult_init(w4_init),
        .mult_done(mult_done), .mult_pp(mult_pp), .energy(w4_energy),
        .energy_valid(w4_ev), .overflow(w4_ovf), .timeout_err(w4_terr), .busy(w4_busy)
    );

    power_accum_ctrl #(.P_W(64), .ACC_W(80), .WINDOW(1), .TIMEOUT(TIMEOUT)) u_w1 (
        .clk(clk), .rst(rst), .smp_valid(smp_valid), .smp_ready(w1_ready),
        .smp_v(smp_v), .smp_i(smp_i), .mult_a(w1_a), .mult_b(w1_b), .mult_init(w1_init),
        .mult_done(mult_done), .mult_pp(mult_pp), .energy(w1_energy),
        .energy_valid(w1_ev), .overflow(w1_ovf), .timeout_err(w1_terr), .busy(w1_busy)
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Expected outputs; index 0 is the window-4 instance, index 1 the window-1 instance.
    logic         exp_ready, exp_init, exp_busy, exp_terr;
    logic [31:0]  exp_a, exp_b;
    logic [127:0] acc_m [2];
    int           cnt_m [2];
    logic [127:0] exp_energy [2];
    logic         exp_ev [2];
    logic         exp_ovf [2];

    function automatic int acc_width(input int d);
        return (d == 0) ? 64 : 80;
    endfunction

    function automatic int win_len(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [63:0] mul(input logic [31:0] a, input logic [31:0] b);
        return {32'd0, a} * {32'd0, b};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0h, want %0h", name, $time, act, exp);
        end
    endtask

    function automatic void model_reset();
        exp_a    = '0;
        exp_b    = '0;
        exp_init = 1'b0;
        exp_busy = 1'b0;
        exp_terr = 1'b0;
        for (int d = 0; d < 2; d++) begin
            acc_m[d]      = '0;
            cnt_m[d]      = 0;
            exp_energy[d] = '0;
            exp_ev[d]     = 1'b0;
            exp_ovf[d]    = 1'b0;
        end
    endfunction

    // Saturating window accumulation in plain wide arithmetic.
    function automatic void model_accumulate(input logic [63:0] p);
        logic [127:0] top;
        logic [127:0] sum;
        for (int d = 0; d < 2; d++) begin
            top = (128'd1 << acc_width(d)) - 128'd1;
            sum = acc_m[d] + {64'd0, p};
            if (sum > top) begin
                acc_m[d]   = top;
                exp_ovf[d] = 1'b1;
            end else begin
                acc_m[d] = sum;
            end
            cnt_m[d]++;
            if (cnt_m[d] == win_len(d)) begin
                exp_energy[d] = acc_m[d];
                exp_ev[d]     = 1'b1;
                acc_m[d]      = '0;
                cnt_m[d]      = 0;
            end
        end
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("w4.smp_ready", 128'(w4_ready), 128'(exp_ready));
            check("w4.mult_init", 128'(w4_init), 128'(exp_init));
            check("w4.busy", 128'(w4_busy), 128'(exp_busy));
            check("w4.mult_a", 128'(w4_a), 128'(exp_a));
            check("w4.mult_b", 128'(w4_b), 128'(exp_b));
            check("w4.timeout_err", 128'(w4_terr), 128'(exp_terr));
            check("w4.energy", 128'(w4_energy), exp_energy[0]);
            check("w4.energy_valid", 128'(w4_ev), 128'(exp_ev[0]));
            check("w4.overflow", 128'(w4_ovf), 128'(exp_ovf[0]));
            check("w1.smp_ready", 128'(w1_ready), 128'(exp_ready));
            check("w1.mult_init", 128'(w1_init), 128'(exp_init));
            check("w1.busy", 128'(w1_busy), 128'(exp_busy));
            check("w1.mult_a", 128'(w1_a), 128'(exp_a));
            check("w1.mult_b", 128'(w1_b), 128'(exp_b));
            check("w1.timeout_err", 128'(w1_terr), 128'(exp_terr));
            check("w1.energy", 128'(w1_energy), exp_energy[1]);
            check("w1.energy_valid", 128'(w1_ev), 128'(exp_ev[1]));
            check("w1.overflow", 128'(w1_ovf), 128'(exp_ovf[1]));
        end
    end

    // Advance one cycle; a published pulse lasts one cycle and takes the overflow flag with it.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            if (exp_ev[d]) begin
                exp_ev[d]  = 1'b0;
                exp_ovf[d] = 1'b0;
            end
        end
    endtask

    task automatic go_idle();
        smp_valid = 1'b0;
        mult_done = 1'b0;
        mult_pp   = rand64();
        exp_busy  = 1'b0;
        exp_ready = 1'b1;
        exp_init  = 1'b0;
    endtask

    task automatic idle_gap(input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            go_idle();
        end
    endtask

    // Cycle 1 is the launch cycle. done is high in [1, stale] and in [rise, rise+hold).
    function automatic bit done_at(input int k, input int rise, input int hold, input int stale);
        return (k >= 1 && k <= stale) || (rise > 0 && k >= rise && k < rise + hold);
    endfunction

    // One sample pair, offered in the current (idle) cycle; returns in the next idle cycle.
    task automatic run_sample(input logic [31:0] v, input logic [31:0] i, input logic [63:0] p,
                              input int rise, input int hold, input int stale, input bit keep_valid);
        bit captured;
        int rel_at;
        int idle_at;
        captured = (rise >= 2) && (rise <= TIMEOUT + 1);
        rel_at   = captured ? rise + 2 : TIMEOUT + 2;
        idle_at  = rel_at;
        while (done_at(idle_at, rise, hold, stale)) idle_at++;
        idle_at++;

        smp_valid = 1'b1;
        smp_v     = v;
        smp_i     = i;
        mult_done = 1'b0;
        mult_pp   = rand64();
        exp_busy  = 1'b0;
        exp_ready = 1'b1;
        exp_init  = 1'b0;

        for (int k = 1; k < idle_at; k++) begin
            tick();
            mult_done = done_at(k, rise, hold, stale);
            mult_pp   = (rise > 0 && k >= rise && k < rise + hold) ? p : rand64();
            smp_valid = keep_valid;
            smp_v     = $urandom;
            smp_i     = $urandom;
            exp_busy  = 1'b1;
            exp_ready = 1'b0;
            exp_init  = (k == 1);
            if (k == 1) begin
                exp_a = v;
                exp_b = i;
            end
            if (k == rel_at) begin
                if (captured) model_accumulate(p);
                else          exp_terr = 1'b1;
            end
        end
        tick();
        go_idle();
    endtask

    // Reset lands in a WAIT cycle; the late done edge afterwards must be ignored.
    task automatic reset_in_wait();
        smp_valid = 1'b1;
        smp_v     = $urandom;
        smp_i     = $urandom;
        exp_busy  = 1'b0;
        exp_ready = 1'b1;
        exp_init  = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            smp_valid = 1'b0;
            mult_done = 1'b0;
            exp_busy  = 1'b1;
            exp_ready = 1'b0;
            exp_init  = (k == 1);
            if (k == 1) begin
                exp_a = smp_v;
                exp_b = smp_i;
            end
            if (k == 3) rst = 1'b1;
        end
        tick();
        rst = 1'b0;
        model_reset();
        exp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            mult_done = 1'b1;
            mult_pp   = rand64();
            smp_valid = 1'b1;
            exp_ready = 1'b0;
        end
        tick();
        go_idle();
    endtask

    logic [31:0] r_v, r_i;
    int          r_rise, r_hold, r_stale;
    bit          r_keep;

    initial begin
        model_reset();
        exp_ready = 1'b1;
        tick();
        chk_en = 1'b1;
        idle_gap(2);
        rst = 1'b0;
        idle_gap(2);

        // Window of four with products 10, 20, 30, 40.
        for (int n = 1; n <= 4; n++)
            run_sample(32'(10 * n), 32'd1, 64'(10 * n), 4, 3, 0, 1'b0);
        check("lit.w4_energy_100", 128'(w4_energy), 128'd100);
        check("lit.w1_energy_40", 128'(w1_energy), 128'd40);
        idle_gap(1);

        // Single sample 3 x 5 with done held for ten cycles and valid kept high.
        run_sample(32'd3, 32'd5, 64'd15, 4, 10, 0, 1'b1);
        check("lit.w1_energy_15", 128'(w1_energy), 128'd15);
        check("lit.w4_energy_held", 128'(w4_energy), 128'd100);
        for (int n = 0; n < 3; n++) begin
            r_v = $urandom;
            r_i = $urandom;
            run_sample(r_v, r_i, mul(r_v, r_i), 5, 2, 0, 1'b0);
        end
        idle_gap(1);

        // Saturation of the 64-bit accumulator.
        run_sample(32'hFFFF_FFFF, 32'h1, 64'hFFFF_FFFF_0000_0000, 3, 2, 0, 1'b0);
        run_sample(32'hFFFF_FFFF, 32'h1, 64'hFFFF_FFFF_0000_0000, 3, 2, 0, 1'b0);
        check("lit.w4_overflow_sticky", 128'(w4_ovf), 128'd1);
        check("lit.w1_no_overflow", 128'(w1_ovf), 128'd0);
        run_sample(32'd1, 32'd1, 64'd1, 6, 1, 0, 1'b0);
        run_sample(32'd1, 32'd1, 64'd1, 6, 1, 0, 1'b0);
        check("lit.w4_energy_sat", 128'(w4_energy), 128'hFFFF_FFFF_FFFF_FFFF);
        check("lit.w4_overflow_cleared", 128'(w4_ovf), 128'd0);
        check("lit.w1_energy_1", 128'(w1_energy), 128'd1);

        // Latest accepted edge, earliest edge, then a multiplier that never answers.
        run_sample(32'd7, 32'd9, 64'd63, TIMEOUT + 1, 3, 0, 1'b0);
        check("lit.w1_energy_63", 128'(w1_energy), 128'd63);
        run_sample(32'd2, 32'd4, 64'd8, 2, 1, 0, 1'b1);
        run_sample(32'd6, 32'd6, 64'd36, 0, 0, 0, 1'b0);
        check("lit.w4_timeout", 128'(w4_terr), 128'd1);
        check("lit.w1_energy_after_timeout", 128'(w1_energy), 128'd8);
        // done already high at launch must not be taken as the product edge.
        run_sample(32'd5, 32'd5, 64'd25, 4, 2, 1, 1'b0);

        for (int n = 0; n < 40; n++) begin
            r_v     = $urandom;
            r_i     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            r_stale = ($urandom_range(0, 4) == 0) ? 1 : 0;
            r_rise  = $urandom_range(2 + r_stale, 12);
            r_hold  = $urandom_range(1, 12);
            r_keep  = 1'($urandom_range(0, 1));
            run_sample(r_v, r_i, mul(r_v, r_i), r_rise, r_hold, r_stale, r_keep);
            idle_gap($urandom_range(0, 2));
        end

        reset_in_wait();
        check("lit.w4_energy_after_rst", 128'(w4_energy), 128'd0);
        check("lit.w4_timeout_after_rst", 128'(w4_terr), 128'd0);
        idle_gap(2);
        for (int n = 0; n < 12; n++) begin
            r_v    = $urandom;
            r_i    = $urandom;
            r_rise = $urandom_range(2, 10);
            r_hold = $urandom_range(1, 10);
            r_keep = 1'($urandom_range(0, 1));
            run_sample(r_v, r_i, mul(r_v, r_i), r_rise, r_hold, 0, r_keep);
        end
        idle_gap(3);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/power_accum_ctrl.md
Name: power_accum_ctrl

Overview:
Downstream consumer and sequencer of the 32-bit shift-add multiplier. It accepts voltage/current sample pairs and launches one multiplication per pair. It captures the 64-bit product on the rising edge of the multiplier's done level and accumulates the products into a windowed energy register. When a full window of samples has been accumulated, it publishes the energy value with a one-cycle valid pulse.

Parameters:
P_W, 64, product width from multiplier
ACC_W, 80, accumulator/energy width (must be >= P_W)
WINDOW, 1000, samples per energy window (>= 1)
TIMEOUT, 255, max cycles waiting for mult_done before error

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
smp_valid  in  1  sample pair available
smp_ready  out  1  block can accept a sample pair this cycle
smp_v  in  32  voltage sample
smp_i  in  32  current sample
mult_a  out  32  multiplicand to multiplier (registered)
mult_b  out  32  multiplier operand (registered)
mult_init  out  1  start pulse to multiplier control
mult_done  in  1  multiplier done level (held high for multiple cycles)
mult_pp  in  P_W  multiplier product, valid while mult_done high
energy  out  ACC_W  last completed window energy
energy_valid  out  1  one-cycle pulse when energy updates
overflow  out  1  sticky: accumulator saturated in current window
timeout_err  out  1  sticky: multiplier failed to respond
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (synchronous, priority over everything, including mid-operation): state=IDLE; mult_a=mult_b=0; mult_init=0; acc=0; sample count=0; energy=0; energy_valid=0; overflow=0; timeout_err=0. Reset mid-multiply abandons the product. After reset the block waits for mult_done low before it launches again (enforced by the REL state rule below).
- Handshake: transfer occurs when smp_valid && smp_ready. smp_ready = (state==IDLE) && !mult_done.
- FSM states and transitions:
  - IDLE: on transfer, register mult_a<=smp_v and mult_b<=smp_i; go to LAUNCH.
  - LAUNCH: mult_init=1 for exactly this one cycle; clear the wait counter; go to WAIT.
  - WAIT: increment the wait counter. If mult_done is high and was low on the previous cycle (rising edge), capture mult_pp into the product register and go to ACCUM. If the counter reaches TIMEOUT first, set timeout_err and go to REL (no accumulation).
  - ACCUM: sum = acc + product, computed at ACC_W+1 bits. If the carry is set, result = all-ones and overflow=1; otherwise result = sum. Increment the sample count.
    - If the count then equals WINDOW: energy <= result, energy_valid=1 for this cycle, acc<=0, count<=0, overflow cleared starting next window.
    - Otherwise: acc <= result.
    - Go to REL.
  - REL: wait until mult_done==0, then go to IDLE. This prevents re-triggering while the multiplier is still in its END hold; mult_init is never asserted in REL.
- mult_init is never high for more than one consecutive cycle. It is never asserted while mult_done is high.
- A mult_done rising edge outside WAIT is ignored. A done level already high on entry to WAIT does not count; a fresh rising edge is required.
- Throughput: at most one sample per multiply plus 3 cycles of overhead plus the done-release time.
- Overflow: once saturated, acc stays at all-ones for the rest of the window. The published energy is all-ones. The overflow flag remains high until the cycle after the energy_valid pulse.
- timeout_err is sticky until rst. Operation continues after a timeout, and the timed-out sample is not counted.
- WINDOW=1: every accumulation produces an energy_valid pulse.

Test Plan:
- Single sample, WINDOW=1: smp_v=3, smp_i=5; mult model returns 15 with done held 10 cycles -> one init pulse, energy=15, energy_valid for 1 cycle, smp_ready low until done falls.
- Window of 4 with products 10, 20, 30, 40 -> energy_valid only after the 4th sample, energy=100, acc cleared; the next window starts from 0.
- Saturation, ACC_W=64: two products of 0xFFFF_FFFF_0000_0000 -> energy=all-ones, overflow=1 at the pulse, overflow=0 afterward.
- Timeout: mult model never asserts done; TIMEOUT=255 -> timeout_err=1 at cycle 256 after init, block returns to IDLE, sample count unchanged.
- smp_valid held continuously with done held 10 cycles -> exactly one init per sample, no init while done high, no product captured twice.
- rst asserted during WAIT -> all outputs at reset values next cycle; the stale done edge that follows is ignored, with no accumulation and no energy_valid.
